// File: rtl/agu_pkg.sv
// Shared types and default widths for the streaming 2D address generator.
package agu_pkg;

  localparam int AGU_IDX_W      = 11;
  localparam int AGU_CNT_W      = 11;
  localparam int AGU_BASE_W     = 20;
  localparam int AGU_ADDR_W     = 32;
  localparam int AGU_ELEM_SHIFT = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } agu_state_e;

  typedef struct packed {
    logic [AGU_BASE_W-1:0] base;
    logic [AGU_IDX_W-1:0]  index_0;
    logic [AGU_IDX_W-1:0]  index_1;
    logic [AGU_CNT_W-1:0]  count_0;
    logic [AGU_CNT_W-1:0]  count_1;
    logic [AGU_IDX_W-1:0]  stride_0;
    logic [AGU_IDX_W-1:0]  stride_1;
  } agu_desc_t;

endpackage

// File: rtl/agu_loop_cnt.sv
// Two-level row/column counter; strobes mark the last column, the last element and a column wrap.
module agu_loop_cnt #(
  parameter int CNT_W = 11
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clr,
  input  logic             i_step,
  input  logic [CNT_W-1:0] i_count_0,
  input  logic [CNT_W-1:0] i_count_1,
  output logic             o_row_end,
  output logic             o_last,
  output logic             o_wrap
);

  logic [CNT_W-1:0] r_col;
  logic [CNT_W-1:0] r_row;

  assign o_row_end = (r_col == (i_count_1 - CNT_W'(1)));
  assign o_last    = o_row_end & (r_row == (i_count_0 - CNT_W'(1)));
  assign o_wrap    = i_step & o_row_end;

  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_col <= '0;
      r_row <= '0;
    end else if (i_step) begin
      if (o_row_end) begin
        r_col <= '0;
        if (!o_last) r_row <= r_row + CNT_W'(1);
      end else begin
        r_col <= r_col + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/agu_stream.sv
// Streaming 2D address generator: accepts one descriptor, then walks its row/column nest
// emitting one registered byte address per accepted handshake.
module agu_stream
  import agu_pkg::*;
#(
  parameter int IDX_W      = AGU_IDX_W,
  parameter int CNT_W      = AGU_CNT_W,
  parameter int BASE_W     = AGU_BASE_W,
  parameter int ADDR_W     = AGU_ADDR_W,
  parameter int ELEM_SHIFT = AGU_ELEM_SHIFT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [BASE_W-1:0] cfg_base_adr,
  input  logic [IDX_W-1:0]  cfg_index_0,
  input  logic [IDX_W-1:0]  cfg_index_1,
  input  logic [CNT_W-1:0]  cfg_count_0,
  input  logic [CNT_W-1:0]  cfg_count_1,
  input  logic [IDX_W-1:0]  cfg_stride_0,
  input  logic [IDX_W-1:0]  cfg_stride_1,
  input  logic              abort,
  output logic              addr_valid,
  input  logic              addr_ready,
  output logic [ADDR_W-1:0] address,
  output logic              addr_row_end,
  output logic              addr_last,
  output logic              done
);

  function automatic logic [ADDR_W-1:0] byte_addr(input logic [ADDR_W-1:0] base_ext,
                                                  input logic [ADDR_W-1:0] off);
    return base_ext + (off << ELEM_SHIFT);
  endfunction

  agu_state_e        r_state, w_state_nxt;
  agu_desc_t         w_desc;
  logic [BASE_W-1:0] r_base;
  logic [CNT_W-1:0]  r_count_0, r_count_1;
  logic [IDX_W-1:0]  r_stride_0, r_stride_1;
  logic [ADDR_W-1:0] r_row_off, r_cur_off, r_address;
  logic [ADDR_W-1:0] w_row_off_nxt, w_cur_off_nxt, w_start_off, w_base_ext;
  logic              w_accept, w_hs, w_zero;
  logic              w_row_end, w_last, w_wrap;

  always_comb begin
    w_desc          = '0;
    w_desc.base     = AGU_BASE_W'(cfg_base_adr);
    w_desc.index_0  = AGU_IDX_W'(cfg_index_0);
    w_desc.index_1  = AGU_IDX_W'(cfg_index_1);
    w_desc.count_0  = AGU_CNT_W'(cfg_count_0);
    w_desc.count_1  = AGU_CNT_W'(cfg_count_1);
    w_desc.stride_0 = AGU_IDX_W'(cfg_stride_0);
    w_desc.stride_1 = AGU_IDX_W'(cfg_stride_1);
  end

  // A simultaneous abort wins over the handshake, so the address is not consumed.
  assign w_accept    = cfg_valid & (r_state == IDLE);
  assign w_hs        = (r_state == RUN) & addr_ready & ~abort;
  assign w_zero      = (w_desc.count_0 == '0) | (w_desc.count_1 == '0);
  assign w_start_off = ADDR_W'({1'b0, w_desc.index_0} + {1'b0, w_desc.index_1});
  assign w_base_ext  = w_accept ? ADDR_W'(w_desc.base) : ADDR_W'(r_base);

  agu_loop_cnt #(.CNT_W(CNT_W)) u_loop_cnt (
    .clk       (clk),
    .rst       (rst),
    .i_clr     (w_accept),
    .i_step    (w_hs),
    .i_count_0 (r_count_0),
    .i_count_1 (r_count_1),
    .o_row_end (w_row_end),
    .o_last    (w_last),
    .o_wrap    (w_wrap)
  );

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: if (w_accept) w_state_nxt = w_zero ? DONE : RUN;
      RUN:  if (abort || (w_hs && w_last)) w_state_nxt = DONE;
      DONE: w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_row_off_nxt = r_row_off;
    w_cur_off_nxt = r_cur_off;
    if (w_accept) begin
      w_row_off_nxt = w_start_off;
      w_cur_off_nxt = w_start_off;
    end else if (w_wrap) begin
      w_row_off_nxt = r_row_off + ADDR_W'(r_stride_0);
      w_cur_off_nxt = r_row_off + ADDR_W'(r_stride_0);
    end else if (w_hs) begin
      w_cur_off_nxt = r_cur_off + ADDR_W'(r_stride_1);
    end
  end

  // Descriptor fields and offsets are pure datapath and need no reset.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_base     <= BASE_W'(w_desc.base);
      r_count_0  <= CNT_W'(w_desc.count_0);
      r_count_1  <= CNT_W'(w_desc.count_1);
      r_stride_0 <= IDX_W'(w_desc.stride_0);
      r_stride_1 <= IDX_W'(w_desc.stride_1);
    end
    r_row_off <= w_row_off_nxt;
    r_cur_off <= w_cur_off_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst)                    r_address <= '0;
    else if (w_accept || w_hs)  r_address <= byte_addr(w_base_ext, w_cur_off_nxt);
  end

  assign cfg_ready    = (r_state == IDLE);
  assign addr_valid   = (r_state == RUN);
  assign addr_row_end = addr_valid & w_row_end;
  assign addr_last    = addr_valid & w_last;
  assign done         = (r_state == DONE);
  assign address      = r_address;

endmodule
